// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared constants, derived widths and scheduler state encoding
// Purpose: one place for channel/feature geometry used by the scheduler, its
//          arbiter and the bus interface.
// Ports:   none (package).
package spike_pkg;

  localparam int CHANNEL_COUNT     = 16;
  localparam int FEATURES          = 3;
  localparam int FEATURE_BIT_DEPTH = 10;

  localparam int CH_W  = $clog2(CHANNEL_COUNT);       // channel index width
  localparam int VEC_W = FEATURES * FEATURE_BIT_DEPTH; // one spike vector
  localparam int LP_W  = $clog2(FEATURES);            // engine level/path width

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_ISSUE  = 2'd1,
    SCHED_WAIT   = 2'd2,
    SCHED_OUTPUT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/spike_sched_if.sv
// rtl/spike_sched_if.sv - request, engine and result signal bundle for spike_sched
// Purpose: groups the per-channel request slots, the engine start/done handshake
//          and the result handshake.
// Modports: master = scheduler side, slave = channels/engine/sink side.
interface spike_sched_if;
  import spike_pkg::*;

  logic [CHANNEL_COUNT-1:0]       req_valid;
  logic [CHANNEL_COUNT*VEC_W-1:0] req_features;
  logic [CHANNEL_COUNT-1:0]       req_ready;

  logic                           eng_start;
  logic [CH_W-1:0]                eng_channel;
  logic [VEC_W-1:0]               eng_features;
  logic                           eng_done;
  logic [LP_W-1:0]                eng_level;
  logic [LP_W-1:0]                eng_path;

  logic                           res_valid;
  logic                           res_ready;
  logic [CH_W-1:0]                res_channel;
  logic [LP_W-1:0]                res_level;
  logic [LP_W-1:0]                res_path;
  logic                           res_error;

  modport master (
    input  req_valid, req_features, eng_done, eng_level, eng_path, res_ready,
    output req_ready, eng_start, eng_channel, eng_features,
           res_valid, res_channel, res_level, res_path, res_error
  );

  modport slave (
    output req_valid, req_features, eng_done, eng_level, eng_path, res_ready,
    input  req_ready, eng_start, eng_channel, eng_features,
           res_valid, res_channel, res_level, res_path, res_error
  );

endinterface

// File: rtl/spike_sched_rr_arbiter.sv
// rtl/spike_sched_rr_arbiter.sv - combinational round-robin priority select
// Purpose: picks the first set request bit at or after ptr_i, ascending, wrapping
//          from CHANNEL_COUNT-1 back to 0.
// Ports:   req_i         request bitmap (full slots)
//          ptr_i         search start position
//          grant_valid_o at least one request set
//          grant_index_o index of the selected request
module rr_arbiter
  import spike_pkg::*;
(
  input  logic [CHANNEL_COUNT-1:0] req_i,
  input  logic [CH_W-1:0]          ptr_i,
  output logic                     grant_valid_o,
  output logic [CH_W-1:0]          grant_index_o
);

  localparam logic [CH_W:0] N_W = (CH_W+1)'(CHANNEL_COUNT);

  logic [CH_W:0]   sum;
  logic [CH_W-1:0] idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_index_o = '0;
    sum           = '0;
    idx           = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      // One extra bit so the wrap works for any channel count, not just powers of two.
      sum = {1'b0, ptr_i} + (CH_W+1)'(i);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      idx = sum[CH_W-1:0];
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_index_o = idx;
      end
    end
  end

endmodule

// File: rtl/spike_sched.sv
// rtl/spike_sched.sv - round-robin scheduler sharing one decision-tree engine across channels
// Purpose: per-channel one-entry slots feed a single engine; results return tagged
//          with the channel, or as an error if the engine times out.
// Ports:   clk    clock
//          reset  asynchronous active-low reset
//          bus    spike_sched_if.master (requests, engine handshake, results)
// Params:  TIMEOUT  cycles allowed from eng_start to eng_done before abort
module spike_sched
  import spike_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  spike_sched_if.master bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_e             state_q;
  logic [CHANNEL_COUNT-1:0] slot_full_q, slot_full_d;
  logic [CHANNEL_COUNT-1:0] slot_load, slot_clear;
  logic [VEC_W-1:0]         slot_vec_q [CHANNEL_COUNT];
  logic [CH_W-1:0]          rr_ptr_q;
  logic [TW-1:0]            tcnt_q;

  logic                     eng_start_q;
  logic [CH_W-1:0]          eng_channel_q;
  logic [VEC_W-1:0]         eng_features_q;
  logic                     res_valid_q;
  logic [CH_W-1:0]          res_channel_q;
  logic [LP_W-1:0]          res_level_q;
  logic [LP_W-1:0]          res_path_q;
  logic                     res_error_q;

  logic                     grant_valid;
  logic [CH_W-1:0]          grant_index;

  rr_arbiter u_arb (
    .req_i         (slot_full_q),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_index_o (grant_index)
  );

  // A slot loads only when empty and clears only when full (granted), so the
  // two never collide on the same channel.
  always_comb begin
    slot_load  = bus.req_valid & ~slot_full_q;
    slot_clear = '0;
    if (state_q == SCHED_ISSUE) begin
      slot_clear[eng_channel_q] = 1'b1;
    end
    slot_full_d = slot_load | (slot_full_q & ~slot_clear);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_full_q <= '0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        slot_vec_q[c] <= '0;
      end
    end else begin
      slot_full_q <= slot_full_d;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        if (slot_load[c]) begin
          slot_vec_q[c] <= bus.req_features[c*VEC_W +: VEC_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= SCHED_IDLE;
      rr_ptr_q       <= '0;
      tcnt_q         <= '0;
      eng_start_q    <= 1'b0;
      eng_channel_q  <= '0;
      eng_features_q <= '0;
      res_valid_q    <= 1'b0;
      res_channel_q  <= '0;
      res_level_q    <= '0;
      res_path_q     <= '0;
      res_error_q    <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      case (state_q)
        SCHED_IDLE: begin
          if (grant_valid) begin
            eng_channel_q  <= grant_index;
            eng_features_q <= slot_vec_q[grant_index];
            eng_start_q    <= 1'b1;  // high for exactly the ISSUE cycle
            state_q        <= SCHED_ISSUE;
          end
        end
        SCHED_ISSUE: begin
          tcnt_q  <= '0;
          state_q <= SCHED_WAIT;
        end
        SCHED_WAIT: begin
          if (bus.eng_done) begin
            res_valid_q   <= 1'b1;
            res_channel_q <= eng_channel_q;
            res_level_q   <= bus.eng_level;
            res_path_q    <= bus.eng_path;
            res_error_q   <= 1'b0;
            state_q       <= SCHED_OUTPUT;
          end else if (tcnt_q == TW'(TIMEOUT-1)) begin
            res_valid_q   <= 1'b1;
            res_channel_q <= eng_channel_q;
            res_level_q   <= '0;
            res_path_q    <= '0;
            res_error_q   <= 1'b1;
            state_q       <= SCHED_OUTPUT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        SCHED_OUTPUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            rr_ptr_q    <= (eng_channel_q == CH_W'(CHANNEL_COUNT-1)) ? '0 : eng_channel_q + 1'b1;
            state_q     <= SCHED_IDLE;
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ~slot_full_q;
  assign bus.eng_start    = eng_start_q;
  assign bus.eng_channel  = eng_channel_q;
  assign bus.eng_features = eng_features_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_channel  = res_channel_q;
  assign bus.res_level    = res_level_q;
  assign bus.res_path     = res_path_q;
  assign bus.res_error    = res_error_q;

endmodule

// File: tb/tb_spike_sched.sv
// tb/tb_spike_sched.sv - scoreboard bench for spike_sched
module tb_spike_sched;
  import spike_pkg::*;

  typedef struct {int ch; logic [VEC_W-1:0] vec;} grant_t;
  typedef struct {int ch; int lvl; int pth; int err;} res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spike_sched_if bus();

  spike_sched #(.TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int n_starts = 0;
  int n_res = 0;
  int last_start_cyc = 0;
  int last_rise_cyc = 0;

  int eng_delay = 3;
  int hang_ch = -1;
  logic [LP_W-1:0] cfg_lvl = '0;
  logic [LP_W-1:0] cfg_pth = '0;
  logic eng_fire = 1'b0;
  logic spur_done = 1'b0;
  logic [LP_W-1:0] fire_lvl = '0;
  logic [LP_W-1:0] fire_pth = '0;

  logic [VEC_W-1:0] vec_tab [CHANNEL_COUNT];
  grant_t exp_grant[$];
  res_t   exp_res[$];

  assign bus.eng_done  = eng_fire | spur_done;
  assign bus.eng_level = fire_lvl;
  assign bus.eng_path  = fire_pth;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_job(input int ch, input int lvl, input int pth, input int err);
    grant_t g;
    res_t r;
    g.ch = ch; g.vec = vec_tab[ch];
    r.ch = ch; r.lvl = lvl; r.pth = pth; r.err = err;
    exp_grant.push_back(g);
    exp_res.push_back(r);
  endtask

  task automatic drive_req(input logic [CHANNEL_COUNT-1:0] mask);
    @(posedge clk); #1;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      if (mask[c]) bus.req_features[c*VEC_W +: VEC_W] = vec_tab[c];
    end
    bus.req_valid = mask;
    req_cyc = cyc;
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_starts < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq(tag, 64'(n_starts >= n), 64'd1);
  endtask

  task automatic wait_res(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_res < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq(tag, 64'(n_res >= n), 64'd1);
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // engine model: answers eng_delay cycles after eng_start, never for hang_ch
  initial begin
    int cnt;
    bit hang;
    cnt = 0;
    hang = 1'b0;
    forever begin
      @(negedge clk);
      eng_fire = 1'b0;
      fire_lvl = '0;
      fire_pth = '0;
      if (!rst_n) begin
        cnt = 0;
      end else if (bus.eng_start) begin
        cnt = eng_delay;
        hang = (int'(bus.eng_channel) == hang_ch);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !hang) begin
          eng_fire = 1'b1;
          fire_lvl = cfg_lvl;
          fire_pth = cfg_pth;
        end
      end
    end
  end

  // monitor: grants and results against the scoreboard
  initial begin
    grant_t g;
    res_t r;
    logic res_prev;
    res_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.eng_start) begin
          n_starts++;
          last_start_cyc = cyc;
          if (exp_grant.size() == 0) begin
            check_eq("unexpected_start", 64'd1, 64'd0);
          end else begin
            g = exp_grant.pop_front();
            check_eq("grant_ch", 64'(bus.eng_channel), 64'(g.ch));
            check_eq("grant_vec", 64'(bus.eng_features), 64'(g.vec));
          end
        end
        if (bus.res_valid && !res_prev) last_rise_cyc = cyc;
        res_prev = bus.res_valid;
        if (bus.res_valid && bus.res_ready) begin
          n_res++;
          if (exp_res.size() == 0) begin
            check_eq("unexpected_res", 64'd1, 64'd0);
          end else begin
            r = exp_res.pop_front();
            check_eq("res_ch", 64'(bus.res_channel), 64'(r.ch));
            check_eq("res_lvl", 64'(bus.res_level), 64'(r.lvl));
            check_eq("res_path", 64'(bus.res_path), 64'(r.pth));
            check_eq("res_err", 64'(bus.res_error), 64'(r.err));
          end
        end
      end else begin
        res_prev = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 64'(bus.req_ready), 64'hFFFF);
    check_eq({tag, "_eng_start"}, 64'(bus.eng_start), 64'd0);
    check_eq({tag, "_eng_channel"}, 64'(bus.eng_channel), 64'd0);
    check_eq({tag, "_eng_features"}, 64'(bus.eng_features), 64'd0);
    check_eq({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check_eq({tag, "_res_fields"},
             64'({bus.res_channel, bus.res_level, bus.res_path, bus.res_error}), 64'd0);
  endtask

  initial begin
    int s7;
    int base_starts;
    int base_res;
    logic [63:0] snap;
    bus.req_valid    = '0;
    bus.req_features = '0;
    bus.res_ready    = 1'b1;
    for (int c = 0; c < CHANNEL_COUNT; c++) vec_tab[c] = VEC_W'($urandom);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // simultaneous requests on 0, 3, 15 with rr_ptr 0, then ch 0 again
    cfg_lvl = 2'd1; cfg_pth = 2'd3; eng_delay = 3;
    push_job(0, 1, 3, 0);
    push_job(3, 1, 3, 0);
    push_job(15, 1, 3, 0);
    drive_req(16'h8009);
    wait_starts(1, 10, "wait_start_ch0");
    check_eq("lat_start_ch0", 64'(last_start_cyc - req_cyc), 64'd2);
    check_eq("ready_rise_cyc", 64'(cyc - last_start_cyc), 64'd1);
    check_eq("ready0_after_issue", 64'(bus.req_ready[0]), 64'd1);
    check_eq("ready_pending", 64'({bus.req_ready[15], bus.req_ready[3]}), 64'd0);
    vec_tab[0] = VEC_W'($urandom);
    push_job(0, 1, 3, 0);
    drive_req(16'h0001);
    wait_res(4, 200, "wait_res_order");

    // single request on ch 5
    vec_tab[5] = {10'd3, 10'd7, 10'd1};
    cfg_lvl = 2'd2; cfg_pth = 2'b10; eng_delay = 9;
    push_job(5, 2, 2, 0);
    drive_req(16'h0020);
    check_eq("ready5_full", 64'(bus.req_ready[5]), 64'd0);
    wait_starts(5, 10, "wait_start_ch5");
    check_eq("lat_start_ch5", 64'(last_start_cyc - req_cyc), 64'd2);
    wait_res(5, 40, "wait_res_ch5");
    check_eq("lat_res_ch5", 64'(last_rise_cyc - last_start_cyc), 64'd10);

    // timeout on ch 7, ch 9 serviced normally afterwards
    hang_ch = 7; cfg_lvl = 2'd3; cfg_pth = 2'd1; eng_delay = 4;
    push_job(7, 0, 0, 1);
    push_job(9, 3, 1, 0);
    drive_req(16'h0280);
    wait_starts(6, 10, "wait_start_ch7");
    s7 = last_start_cyc;
    wait_res(6, 150, "wait_res_timeout");
    check_eq("lat_timeout", 64'(last_rise_cyc - s7), 64'd65);
    wait_res(7, 50, "wait_res_ch9");
    hang_ch = -1;

    // result held for 20 cycles; other slots keep loading; spurious done in OUTPUT
    bus.res_ready = 1'b0;
    eng_delay = 2;
    push_job(10, 3, 1, 0);
    drive_req(16'h0400);
    for (int k = 0; k < 30 && !bus.res_valid; k++) @(posedge clk);
    #1;
    check_eq("hold_res_valid_rise", 64'(bus.res_valid), 64'd1);
    snap = 64'({bus.res_valid, bus.res_channel, bus.res_level, bus.res_path, bus.res_error});
    base_starts = n_starts;
    push_job(11, 3, 1, 0);
    push_job(12, 3, 1, 0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        bus.req_features[11*VEC_W +: VEC_W] = vec_tab[11];
        bus.req_features[12*VEC_W +: VEC_W] = vec_tab[12];
        bus.req_valid = 16'h1800;
      end
      if (k == 3) bus.req_valid = '0;
      if (k == 5) spur_done = 1'b1;
      if (k == 6) spur_done = 1'b0;
      check_eq("hold_res_stable",
               64'({bus.res_valid, bus.res_channel, bus.res_level, bus.res_path, bus.res_error}), snap);
    end
    check_eq("hold_other_slots_loaded", 64'({bus.req_ready[12], bus.req_ready[11]}), 64'd0);
    check_eq("hold_no_start", 64'(n_starts), 64'(base_starts));
    bus.res_ready = 1'b1;
    wait_res(10, 100, "wait_res_after_hold");

    // spurious eng_done while idle
    base_starts = n_starts;
    base_res = n_res;
    @(posedge clk); #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("idle_spur_starts", 64'(n_starts), 64'(base_starts));
    check_eq("idle_spur_res", 64'(n_res), 64'(base_res));
    check_eq("idle_spur_valid", 64'(bus.res_valid), 64'd0);

    // reset during WAIT aborts the job; ch 4 slot is also dropped
    hang_ch = 1;
    begin
      grant_t g;
      g.ch = 1; g.vec = vec_tab[1];
      exp_grant.push_back(g);
    end
    drive_req(16'h0002);
    wait_starts(base_starts + 1, 10, "wait_start_ch1");
    drive_req(16'h0010);
    check_eq("ready4_full", 64'(bus.req_ready[4]), 64'd0);
    check_eq("wait_no_valid", 64'(bus.res_valid), 64'd0);
    base_res = n_res;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hang_ch = -1;
    check_eq("rst_no_result", 64'(n_res), 64'(base_res));

    // ch 2 after reset
    cfg_lvl = 2'd0; cfg_pth = 2'd1; eng_delay = 3;
    push_job(2, 0, 1, 0);
    base_starts = n_starts;
    drive_req(16'h0004);
    wait_starts(base_starts + 1, 10, "wait_start_ch2");
    check_eq("lat_start_ch2", 64'(last_start_cyc - req_cyc), 64'd2);
    wait_res(base_res + 1, 40, "wait_res_ch2");

    repeat (3) @(posedge clk);
    check_eq("grant_q_empty", 64'(exp_grant.size()), 64'd0);
    check_eq("res_q_empty", 64'(exp_res.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
